// File: rtl/ef_apb_irq_frontend.sv
// ef_apb_irq_frontend: APB slave with a local interrupt page (IM/MIS/RIS/ICR)
// and a timed pass-through bridge to a core request/acknowledge bus.
module ef_apb_irq_frontend #(
   parameter int                   NUM_FLAGS = 9,
   parameter logic [NUM_FLAGS-1:0] EDGE_MASK = '0,
   parameter int                   TIMEOUT   = 255
) (
   input  logic                 PCLK,
   input  logic                 PRESET,
   input  logic                 PSEL,
   input  logic                 PENABLE,
   input  logic                 PWRITE,
   input  logic [15:0]          PADDR,
   input  logic [31:0]          PWDATA,
   output logic [31:0]          PRDATA,
   output logic                 PREADY,
   output logic                 PSLVERR,
   output logic                 core_req,
   output logic                 core_we,
   output logic [7:0]           core_adr,
   output logic [31:0]          core_wdata,
   input  logic [31:0]          core_rdata,
   input  logic                 core_ack,
   input  logic [NUM_FLAGS-1:0] flags_i,
   output logic                 irq
);
   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
   state_t state_q, state_d;
   logic [NUM_FLAGS-1:0] im_q, im_d, ris_q, ris_d, flag_q, clr, mis;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] data_q, data_d, wdata_q, wdata_d, lrd;
   logic [7:0] adr_q, adr_d, off;
   logic err_q, err_d, req_q, req_d, we_q, we_d, access, local_acc;
   always_comb begin
      access    = PSEL & PENABLE;
      local_acc = access & (PADDR[15:8] == 8'hFF);
      off       = PADDR[7:0];
      im_d      = (local_acc & PWRITE & off == 8'h00) ? PWDATA[NUM_FLAGS-1:0] : im_q;
      clr       = (local_acc & PWRITE & off == 8'h0C) ? PWDATA[NUM_FLAGS-1:0] : '0;
      // a new edge outranks a same-cycle clear, so no event is lost
      ris_d     = (EDGE_MASK & ((ris_q & ~clr) | (flags_i & ~flag_q))) | (~EDGE_MASK & flags_i);
      mis       = ris_q & im_q;
      lrd       = off == 8'h00 ? 32'(im_q) : off == 8'h04 ? 32'(mis) :
                  off == 8'h08 ? 32'(ris_q) : off == 8'h0C ? 32'h0 : 32'hDEADBEEF;
   end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      err_d   = err_q;
      req_d   = req_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: if (access & ~local_acc) begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = PWRITE;
            adr_d   = PADDR[7:0];
            wdata_d = PWDATA;
            cnt_d   = '0;
         end
         WAIT: if (core_ack) begin
            state_d = DONE;
            req_d   = 1'b0;
            data_d  = core_rdata;
            err_d   = 1'b0;
         end else if (cnt_q == 16'(TIMEOUT - 1)) begin
            state_d = DONE;
            req_d   = 1'b0;
            data_d  = 32'hDEADBEEF;
            err_d   = 1'b1;
         end else cnt_d = cnt_q + 16'd1;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         im_q    <= '0;
         ris_q   <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
         req_q   <= req_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
         im_q    <= im_d;
         ris_q   <= ris_d;
         flag_q  <= flags_i;
      end
   end
   // local completions are combinational, so gate them off while reset is held
   assign PREADY     = ~PRESET & (local_acc | state_q == DONE);
   assign PSLVERR    = ~PRESET & (state_q == DONE) & err_q;
   assign PRDATA     = PRESET ? 32'h0 : state_q == DONE ? data_q : (local_acc & ~PWRITE) ? lrd : 32'h0;
   assign core_req   = req_q;
   assign core_we    = we_q;
   assign core_adr   = adr_q;
   assign core_wdata = wdata_q;
   assign irq        = |mis;
endmodule

// File: tb/tb_ef_apb_irq_frontend.sv
// tb_ef_apb_irq_frontend: directed APB sequence with a scoreboard of expected completions.
module tb_ef_apb_irq_frontend;
   logic clk = 1'b0, rst = 1'b1;
   logic PSEL = 0, PENABLE = 0, PWRITE = 0, PREADY, PSLVERR, core_req, core_we, core_ack = 0, irq;
   logic [15:0] PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA, core_wdata, core_rdata = '0;
   logic [7:0] core_adr;
   logic [8:0] flags_i = '0;
   int vec = 0, miss = 0;
   typedef struct {string tag; logic rd; logic [31:0] rdata; logic err; int lat;} sb_t;
   sb_t sb[$];

   always #5 clk = ~clk;

   ef_apb_irq_frontend #(.NUM_FLAGS(9), .EDGE_MASK(9'h001), .TIMEOUT(4)) dut (
      .PCLK(clk), .PRESET(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .core_req(core_req), .core_we(core_we), .core_adr(core_adr), .core_wdata(core_wdata),
      .core_rdata(core_rdata), .core_ack(core_ack), .flags_i(flags_i), .irq(irq));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ack_n: cycle index (0 = first access cycle) at which core_ack is pulsed
   task automatic apb(input string tag, input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic [8:0] fl, input int ack_n, input logic [31:0] ack_d,
                      input logic rd, input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      sb_t e;
      int n;
      e.tag = tag; e.rd = rd; e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
      sb.push_back(e);
      @(negedge clk);
      PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d;
      @(negedge clk);
      PENABLE = 1; flags_i = fl;
      for (n = 0; n < 40; n++) begin
         #1;
         if (PREADY) break;
         if (n == 1) begin
            chk({tag, "_req"}, 32'(core_req), 32'd1);
            chk({tag, "_adr"}, {24'h0, core_adr}, {24'h0, a[7:0]});
            chk({tag, "_we"}, 32'(core_we), 32'(w));
            if (w) chk({tag, "_wdata"}, core_wdata, d);
         end
         core_ack = (n == ack_n); core_rdata = ack_d;
         @(negedge clk);
      end
      e = sb.pop_front();
      chk({e.tag, "_lat"}, 32'(n), 32'(e.lat));
      if (e.rd) chk({e.tag, "_rdata"}, PRDATA, e.rdata);
      chk({e.tag, "_slverr"}, 32'(PSLVERR), 32'(e.err));
      chk({e.tag, "_req_done"}, 32'(core_req), 32'd0);
      @(negedge clk);
      PSEL = 0; PENABLE = 0; core_ack = 0;
   endtask

   initial begin
      PSEL = 1; PENABLE = 1; PADDR = 16'hFF08;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_pready", 32'(PREADY), 32'd0);
      chk("rst_prdata", PRDATA, 32'h0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_req", 32'(core_req), 32'd0);
      chk("rst_slverr", 32'(PSLVERR), 32'd0);
      @(negedge clk);
      rst = 0; PSEL = 0; PENABLE = 0;
      apb("im_rst", 0, 16'hFF00, 0, flags_i, -1, 0, 1, 32'h0, 0, 0);
      apb("im_wr", 1, 16'hFF00, 32'h1, flags_i, -1, 0, 0, 0, 0, 0);
      // edge flag 0: one-cycle pulse
      @(negedge clk); flags_i = 9'h001;
      @(negedge clk); flags_i = 9'h000;
      #1; chk("edge_irq", 32'(irq), 32'd1);
      apb("edge_ris", 0, 16'hFF08, 0, flags_i, -1, 0, 1, 32'h1, 0, 0);
      apb("edge_mis", 0, 16'hFF04, 0, flags_i, -1, 0, 1, 32'h1, 0, 0);
      apb("edge_icr", 1, 16'hFF0C, 32'h1, flags_i, -1, 0, 0, 0, 0, 0);
      apb("edge_clr", 0, 16'hFF08, 0, flags_i, -1, 0, 1, 32'h0, 0, 0);
      #1; chk("edge_irq_clr", 32'(irq), 32'd0);
      // level flag 3
      apb("lvl_im", 1, 16'hFF00, 32'h8, flags_i, -1, 0, 0, 0, 0, 0);
      @(negedge clk); flags_i = 9'h008;
      @(negedge clk); #1; chk("lvl_irq", 32'(irq), 32'd1);
      apb("lvl_mis", 0, 16'hFF04, 0, flags_i, -1, 0, 1, 32'h8, 0, 0);
      apb("lvl_icr", 1, 16'hFF0C, 32'h8, flags_i, -1, 0, 0, 0, 0, 0);
      apb("lvl_ris", 0, 16'hFF08, 0, flags_i, -1, 0, 1, 32'h8, 0, 0);
      @(negedge clk); flags_i = 9'h000;
      #1; chk("lvl_drop_hold", 32'(irq), 32'd1);
      @(negedge clk); #1; chk("lvl_drop", 32'(irq), 32'd0);
      // map corners
      apb("unmapped", 0, 16'hFF10, 0, flags_i, -1, 0, 1, 32'hDEADBEEF, 0, 0);
      apb("icr_rd", 0, 16'hFF0C, 0, flags_i, -1, 0, 1, 32'h0, 0, 0);
      apb("ris_wr", 1, 16'hFF08, 32'h1FF, flags_i, -1, 0, 0, 0, 0, 0);
      apb("ris_ro", 0, 16'hFF08, 0, flags_i, -1, 0, 1, 32'h0, 0, 0);
      apb("im_rb", 0, 16'hFF00, 0, flags_i, -1, 0, 1, 32'h8, 0, 0);
      // core bridge
      apb("core_rd", 0, 16'h0004, 0, flags_i, 3, 32'h1234, 1, 32'h00001234, 0, 4);
      apb("core_wr", 1, 16'h0010, 32'hCAFE, flags_i, 1, 32'h5555, 0, 0, 0, 2);
      apb("core_to", 0, 16'h0020, 0, flags_i, -1, 0, 1, 32'hDEADBEEF, 1, 5);
      apb("ack_idle", 0, 16'h0024, 0, flags_i, 0, 32'h7777, 1, 32'hDEADBEEF, 1, 5);
      apb("ack_last", 0, 16'h0028, 0, flags_i, 4, 32'h4242, 1, 32'h4242, 0, 5);
      // edge rises in the same cycle as its ICR clear
      apb("race_im", 1, 16'hFF00, 32'h1, flags_i, -1, 0, 0, 0, 0, 0);
      apb("race_icr", 1, 16'hFF0C, 32'h1, 9'h001, -1, 0, 0, 0, 0, 0);
      flags_i = 9'h000;
      apb("race_ris", 0, 16'hFF08, 0, flags_i, -1, 0, 1, 32'h1, 0, 0);
      #1; chk("race_irq", 32'(irq), 32'd1);
      // reset mid-WAIT
      @(negedge clk); PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 16'h0030;
      @(negedge clk); PENABLE = 1;
      repeat (2) @(negedge clk);
      #1; chk("abort_req_pre", 32'(core_req), 32'd1);
      #2; rst = 1;
      #1;
      chk("abort_req", 32'(core_req), 32'd0);
      chk("abort_irq", 32'(irq), 32'd0);
      chk("abort_pready", 32'(PREADY), 32'd0);
      @(negedge clk); rst = 0; PSEL = 0; PENABLE = 0;
      apb("abort_im", 0, 16'hFF00, 0, flags_i, -1, 0, 1, 32'h0, 0, 0);
      apb("after_rst", 0, 16'h0008, 0, flags_i, 2, 32'hABCD, 1, 32'h0000ABCD, 0, 3);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
